// File: rtl/cpu_pkg.sv
// Shared opcodes and fetch-stage state encoding for the CPU front end.
package cpu_pkg;

    localparam logic [7:0] NOP_OPCODE   = 8'h00;
    localparam logic [7:0] STALL_OPCODE = 8'hFF;
    localparam logic [3:0] MOV1_PREFIX  = 4'b1110;
    localparam logic [3:0] MOV2_PREFIX  = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        STALL
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter: a jump load wins over the post-fetch increment; arithmetic wraps.
module pc_register #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (jump) begin
            pc_d = jump_target;
        end else if (inc) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding memory request, single-cycle issue strobe, local stall
// opcode handling and jump redirection with discard of an in-flight response.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH     = 8,
    parameter int STALL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic                mem_valid,
    input  logic [7:0]          mem_data,
    output logic [7:0]          instruction,
    output logic                enabled,
    output logic [PC_WIDTH-1:0] pc,
    output logic                stall_active
);

    localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 1);

    fetch_state_t        state_q, state_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                flush_q, flush_d;
    logic                mem_req_q, mem_req_d;
    logic [PC_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]          instr_q, instr_d;
    logic                enabled_q, enabled_d;
    logic                stall_q, stall_d;
    logic                pc_inc;
    logic                start_fetch;
    logic [PC_WIDTH-1:0] pc_cur;
    logic [PC_WIDTH-1:0] fetch_pc;

    pc_register #(
        .PC_WIDTH(PC_WIDTH)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .jump       (jump_valid),
        .jump_target(jump_target),
        .inc        (pc_inc),
        .pc         (pc_cur)
    );

    // A new request always targets the pc the register will hold after this edge;
    // pc never increments in the same cycle a request starts.
    assign fetch_pc = jump_valid ? jump_target : pc_cur;

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        flush_d     = flush_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        instr_d     = NOP_OPCODE;
        enabled_d   = 1'b0;
        stall_d     = 1'b0;
        pc_inc      = 1'b0;
        start_fetch = 1'b0;

        case (state_q)
            IDLE: begin
                start_fetch = run;
            end
            FETCH: begin
                if (mem_valid) begin
                    if (jump_valid || flush_q) begin
                        flush_d     = 1'b0;
                        start_fetch = 1'b1;
                    end else if (mem_data == STALL_OPCODE) begin
                        pc_inc      = 1'b1;
                        state_d     = STALL;
                        stall_cnt_d = STALL_LAST;
                        stall_d     = 1'b1;
                        mem_req_d   = 1'b0;
                    end else begin
                        pc_inc    = 1'b1;
                        instr_d   = mem_data;
                        enabled_d = 1'b1;
                        state_d   = ISSUE;
                        mem_req_d = 1'b0;
                    end
                end else if (jump_valid) begin
                    flush_d = 1'b1;
                end
            end
            ISSUE: begin
                if (run) begin
                    start_fetch = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            STALL: begin
                if (jump_valid || stall_cnt_q == '0) begin
                    if (run) begin
                        start_fetch = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    stall_cnt_d = stall_cnt_q - CNT_W'(1);
                    stall_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_fetch) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            flush_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            instr_q     <= NOP_OPCODE;
            enabled_q   <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_q     <= flush_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            instr_q     <= instr_d;
            enabled_q   <= enabled_d;
            stall_q     <= stall_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign instruction  = instr_q;
    assign enabled      = enabled_q;
    assign pc           = pc_cur;
    assign stall_active = stall_q;

endmodule
